// File: rtl/key_debouncer.sv
// key_debouncer: conditions raw active-low push buttons for the display and audio logic.
// Each lane is synchronised with two flops and filtered by a four-state debounce FSM that
// only accepts a level change after DEBOUNCE_CYCLES consecutive stable samples.
//
// Ports:
//   clk          - system clock (25 MHz pixel clock)
//   rst_n        - asynchronous active-low reset
//   key_n        - raw buttons, asynchronous, 0 = pressed
//   count_en     - allows accepted presses to bump press_count
//   clear_counts - synchronous clear of all press counters
//   key_held     - debounced level, 1 = pressed
//   key_press    - one-cycle pulse per accepted press
//   key_release  - one-cycle pulse per accepted release
//   any_press    - OR of key_press
//   press_count  - 8-bit saturating counter per lane, lane i at [8i+7:8i]
module key_debouncer #(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_KEYS-1:0]     key_n,
  input  logic                    count_en,
  input  logic                    clear_counts,
  output logic [NUM_KEYS-1:0]     key_held,
  output logic [NUM_KEYS-1:0]     key_press,
  output logic [NUM_KEYS-1:0]     key_release,
  output logic                    any_press,
  output logic [8*NUM_KEYS-1:0]   press_count
);

  typedef enum logic [1:0] {StIdle, StPressChk, StHeld, StRelChk} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser, reset to the released level.
  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] pressed_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  // Debounce FSM state and stability counters.
  state_e           state_q [NUM_KEYS];
  state_e           state_d [NUM_KEYS];
  logic [CNT_W-1:0] cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0] cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] press_d, press_q;
  logic [NUM_KEYS-1:0] release_d, release_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (pressed_s[i]) begin
            state_d[i] = StPressChk;
            cnt_d[i]   = '0;
          end
        end
        StPressChk: begin
          if (!pressed_s[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LastCnt) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StHeld: begin
          if (!pressed_s[i]) begin
            state_d[i] = StRelChk;
            cnt_d[i]   = '0;
          end
        end
        StRelChk: begin
          if (pressed_s[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LastCnt) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Pulse next-values fire on the accepting edge so pulse and key_held move together.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    key_held  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_d[i]   = (state_q[i] == StPressChk) && pressed_s[i] && (cnt_q[i] == LastCnt);
      release_d[i] = (state_q[i] == StRelChk) && !pressed_s[i] && (cnt_q[i] == LastCnt);
      key_held[i]  = (state_q[i] == StHeld) || (state_q[i] == StRelChk);
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_press   = |press_q;

  // Press counters consume the registered pulse, so they update one edge after it.
  logic [7:0] count_q [NUM_KEYS];
  logic [7:0] count_d [NUM_KEYS];

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      count_d[i] = count_q[i];
      if (clear_counts) begin
        count_d[i] = (press_q[i] && count_en) ? 8'd1 : 8'd0;
      end else if (press_q[i] && count_en && (count_q[i] != 8'hFF)) begin
        count_d[i] = count_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  always_comb begin
    press_count = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_count[8*i +: 8] = count_q[i];
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with D=4. Expected pulses are queued when stimulus
// is driven and matched by a negedge monitor; expected counts come from a small model.
module tb_key_debouncer;

  localparam int unsigned NK  = 3;
  localparam int unsigned D   = 4;
  localparam int          LAT = D + 3;  // drive edge to pulse-visible edge

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic          count_en = 1'b1;
  logic          clear_counts = 1'b0;
  logic [NK-1:0] key_held, key_press, key_release;
  logic          any_press;
  logic [8*NK-1:0] press_count;

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .count_en    (count_en),
    .clear_counts(clear_counts),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .any_press   (any_press),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rel;
    logic [NK-1:0] mask;
    int          when;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_cnt[NK];

  function automatic logic [8*NK-1:0] exp_pc();
    logic [8*NK-1:0] v;
    v = '0;
    for (int i = 0; i < NK; i++) v[8*i +: 8] = exp_cnt[i][7:0];
    return v;
  endfunction

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input logic [NK-1:0] m);
    ev_t e;
    e.rel = 1'b0; e.mask = m; e.when = cyc + LAT;
    exp_q.push_back(e);
    for (int i = 0; i < NK; i++)
      if (m[i] && count_en && exp_cnt[i] < 255) exp_cnt[i]++;
  endtask

  task automatic expect_release(input logic [NK-1:0] m);
    ev_t e;
    e.rel = 1'b1; e.mask = m; e.when = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every pulse must match the queue head at the predicted cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      checks++;
      if (any_press !== |key_press) begin
        failures++;
        $display("FAIL any_press cyc=%0d got=%b want=%b", cyc, any_press, |key_press);
      end
      if ((key_press | key_release) != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b", cyc, key_press,
                   key_release);
        end else begin
          e = exp_q.pop_front();
          if ((e.rel ? key_release : key_press) !== e.mask ||
              (e.rel ? key_press : key_release) !== '0 || cyc != e.when) begin
            failures++;
            $display("FAIL pulse_match cyc=%0d press=%b release=%b want_rel=%0d mask=%b at=%0d",
                     cyc, key_press, key_release, e.rel, e.mask, e.when);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].when < cyc) begin
        checks++;
        failures++;
        e = exp_q.pop_front();
        $display("FAIL missing_pulse cyc=%0d want_rel=%0d mask=%b at=%0d", cyc, e.rel, e.mask,
                 e.when);
      end
    end
  end

  task automatic test_reset();
    step(2);
    checks += 5;
    if (key_held !== '0) begin failures++; $display("FAIL rst_held got=%b want=0", key_held); end
    if (key_press !== '0) begin failures++; $display("FAIL rst_press got=%b want=0", key_press); end
    if (key_release !== '0) begin
      failures++; $display("FAIL rst_release got=%b want=0", key_release);
    end
    if (any_press !== 1'b0) begin failures++; $display("FAIL rst_any got=%b want=0", any_press); end
    if (press_count !== '0) begin
      failures++; $display("FAIL rst_count got=%h want=0", press_count);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_clean_press();
    key_n[0] = 1'b0;
    expect_press(3'b001);
    step(20);
    checks += 2;
    if (key_held !== 3'b001) begin
      failures++; $display("FAIL clean_held got=%b want=001", key_held);
    end
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL clean_count got=%h want=%h", press_count, exp_pc());
    end
    key_n[0] = 1'b1;
    expect_release(3'b001);
    step(12);
    checks++;
    if (key_held !== 3'b000) begin
      failures++; $display("FAIL clean_release_held got=%b want=000", key_held);
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 2; k++) begin
      key_n[1] = 1'b0; step(2);
      key_n[1] = 1'b1; step(2);
    end
    step(10);
    checks += 2;
    if (key_held !== 3'b000) begin
      failures++; $display("FAIL bounce_held got=%b want=000", key_held);
    end
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL bounce_count got=%h want=%h", press_count, exp_pc());
    end
    key_n[1] = 1'b0;
    expect_press(3'b010);
    step(10);
    checks++;
    if (key_held !== 3'b010) begin
      failures++; $display("FAIL bounce_accept_held got=%b want=010", key_held);
    end
    key_n[1] = 1'b1;
    expect_release(3'b010);
    step(12);
  endtask

  task automatic test_release_gating();
    count_en = 1'b0;
    key_n[2] = 1'b0;
    expect_press(3'b100);
    step(12);
    key_n[2] = 1'b1;
    expect_release(3'b100);
    step(12);
    checks++;
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL gating_count got=%h want=%h", press_count, exp_pc());
    end
    count_en = 1'b1;
  endtask

  task automatic test_saturation_clear();
    for (int k = 0; k < 300; k++) begin
      key_n[0] = 1'b0; expect_press(3'b001); step(8);
      key_n[0] = 1'b1; expect_release(3'b001); step(8);
    end
    checks++;
    if (press_count[7:0] !== 8'd255) begin
      failures++; $display("FAIL sat_count got=%0d want=255", press_count[7:0]);
    end
    clear_counts = 1'b1; step(1); clear_counts = 1'b0;
    for (int i = 0; i < NK; i++) exp_cnt[i] = 0;
    checks++;
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL clear_count got=%h want=%h", press_count, exp_pc());
    end
    // Clear lands on the edge that consumes the press pulse.
    key_n[0] = 1'b0;
    expect_press(3'b001);
    step(LAT);
    clear_counts = 1'b1; step(1); clear_counts = 1'b0;
    checks++;
    if (press_count[7:0] !== 8'd1) begin
      failures++; $display("FAIL clear_with_press got=%0d want=1", press_count[7:0]);
    end
    step(2);
    key_n[0] = 1'b1;
    expect_release(3'b001);
    step(12);
  endtask

  task automatic test_simultaneous();
    key_n = 3'b000;
    expect_press(3'b111);
    step(10);
    checks += 2;
    if (key_held !== 3'b111) begin
      failures++; $display("FAIL simul_held got=%b want=111", key_held);
    end
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL simul_count got=%h want=%h", press_count, exp_pc());
    end
    key_n = 3'b111;
    expect_release(3'b111);
    step(12);
  endtask

  task automatic test_reset_mid();
    key_n[0] = 1'b0;
    step(5);  // lane 0 now in PRESS_CHK with cnt=2
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NK; i++) exp_cnt[i] = 0;
    checks += 4;
    if (key_held !== '0) begin failures++; $display("FAIL mid_rst_held got=%b want=0", key_held); end
    if (key_press !== '0 || key_release !== '0) begin
      failures++; $display("FAIL mid_rst_pulses got=%b/%b want=0/0", key_press, key_release);
    end
    if (any_press !== 1'b0) begin
      failures++; $display("FAIL mid_rst_any got=%b want=0", any_press);
    end
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL mid_rst_count got=%h want=%h", press_count, exp_pc());
    end
    step(2);
    rst_n = 1'b1;
    expect_press(3'b001);
    step(12);
    checks += 2;
    if (key_held !== 3'b001) begin
      failures++; $display("FAIL post_rst_held got=%b want=001", key_held);
    end
    if (press_count !== exp_pc()) begin
      failures++; $display("FAIL post_rst_count got=%h want=%h", press_count, exp_pc());
    end
    key_n[0] = 1'b1;
    expect_release(3'b001);
    step(12);
  endtask

  initial begin
    for (int i = 0; i < NK; i++) exp_cnt[i] = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_gating();
    test_saturation_clear();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Input-conditioning stage between the raw active-low KEY buttons and their consumers: the game display (lane hits) and the audio controller (button tones). Each lane passes through a two-flop synchroniser and a per-lane debounce FSM. The block produces a clean held level, one-cycle press and release pulses, and a saturating per-lane press counter for play statistics. It runs on the 25 MHz pixel clock, so all outputs are already in the display clock domain.

## Interface
Parameters:
- NUM_KEYS, 3, number of button lanes.
- DEBOUNCE_CYCLES, 250000, stable-sample count D required to accept a change (10 ms at 25 MHz); must be ≥ 2.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 25 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- key_n  input  NUM_KEYS  raw buttons, asynchronous, active-low (0 = pressed).
- count_en  input  1  when 1, accepted presses increment press_count (tie to game_active).
- clear_counts  input  1  synchronous clear of all press counters.
- key_held  output  NUM_KEYS  debounced level, 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle pulse on an accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse on an accepted release.
- any_press  output  1  OR of key_press, same cycle.
- press_count  output  8*NUM_KEYS  lane i occupies bits [8i+7:8i]; unsigned, saturating.

## Operation
- Synchroniser: two flops per lane, reset to 1 (released). s = ~sync2 is the lane's synchronised pressed sample.
- Per-lane FSM states, all reset to IDLE:
  - IDLE (stable released): if s=1, go to PRESS_CHK with cnt=0.
  - PRESS_CHK: if s=0, return to IDLE and clear cnt, with no pulse. If s=1 and cnt=D-1, go to HELD and assert key_press. Otherwise cnt+1.
  - HELD (stable pressed): if s=0, go to REL_CHK with cnt=0.
  - REL_CHK: if s=1, return to HELD and clear cnt, with no pulse. If s=0 and cnt=D-1, go to IDLE and assert key_release. Otherwise cnt+1.
- key_held = 1 in HELD and REL_CHK, 0 in IDLE and PRESS_CHK. Its value is registered, so it changes on the same edge as the pulse.
- key_press and key_release are registered. Each is high for exactly one cycle per accepted transition and never high together on one lane.
- press_count[i]:
  - clear_counts=1 sets the count to 0. If key_press[i] and count_en are also high that cycle, it sets the count to 1 instead.
  - Otherwise the count increments on an edge where key_press[i]=1 and count_en=1. It holds at 255.
  - The increment happens on the edge after the key_press cycle (the count uses the registered pulse).
- Lanes are fully independent. Simultaneous presses on several lanes each produce their own pulse and count in the same cycle.
- Reset (asynchronous, any time including mid-debounce):
  - All FSMs go to IDLE and cnt to 0.
  - Sync flops go to 1.
  - key_held, key_press, key_release, any_press and all press_count go to 0.
- After reset release with a key already held down, the key is treated as a new press: one key_press pulse after the normal latency.

## Timing
- Press latency: let key_n[i] first be sampled low at edge 0 and stay low. key_press[i] and key_held[i] rise after edge D+2. key_press[i] falls after edge D+3.
- Release latency: symmetric, D+2 edges from the first high sample to key_release[i] rising and key_held[i] falling.
- Any bounce inside the check window restarts the full D-cycle window from the next stable sample.
- A glitch of fewer than D synchronised cycles never changes key_held or produces a pulse.
- Minimum press-to-press spacing for two accepted presses is 2·(D+1) cycles.
- any_press is combinational from the key_press registers, with zero extra latency.

## Test plan
(All scenarios use D=4.)
- Clean press: drive key_n[0] low at edge 0 and hold it for 20 cycles, count_en=1. Expect key_press[0]=1 only in the cycle after edge 6, key_held[0]=1 from edge 6 onward, press_count[7:0]=1.
- Bounce rejection: toggle key_n[1] low/high/low/high with 2-cycle periods, then leave it high. Expect no key_press[1] and key_held[1]=0. Then hold it low for 10 cycles: expect exactly one press pulse.
- Release and count_en gating: with count_en=0, press and release lane 2. Expect key_release[2] D+2 edges after the release, and press_count lane 2 unchanged at 0.
- Saturation and clear: with count_en=1, perform 300 accepted presses on lane 0. Expect press_count[7:0]=255. Assert clear_counts in the same cycle as a key_press: expect 1.
- Simultaneous lanes: drive all three key_n low on the same edge. Expect key_press=3'b111 for one cycle, any_press=1 for one cycle, and all counts incremented.
- Reset mid-operation: assert rst_n=0 while lane 0 is in PRESS_CHK (cnt=2). Expect all outputs 0 immediately. Release reset with the key still low: expect one key_press[0] D+2 edges after the first post-reset sample.
